// File: rtl/wd_pkg.sv
// ---------------------------------------------------------------------------
// wd_pkg
// Shared definitions for the watchdog kicker and the watchdog kick decode:
//   wd_state_e      kicker FSM states
//   WD_KICK_ADDR_U  address bits [21:17] of the kick location $300001
//   WD_KICK_A23/A22 upper decode line levels for the kick location
// ---------------------------------------------------------------------------
package wd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        FAIL   = 3'd4
    } wd_state_e;

    localparam logic [4:0] WD_KICK_ADDR_U = 5'b11000;
    localparam logic       WD_KICK_A23    = 1'b0;
    localparam logic       WD_KICK_A22    = 1'b0;

endpackage

// File: rtl/watchdog_kicker.sv
// ---------------------------------------------------------------------------
// watchdog_kicker
// Bus-master stub that periodically issues a 68k byte write to $300001 to
// service the system watchdog. The watchdog's kick decode drives WDRESET,
// which asynchronously clears this block and so acknowledges the kick.
//
// Optional feature: define WDKICK_INHIBIT_EN to add the kick_inhibit port.
//
// Ports
//   WDCLK         in  clock shared with the watchdog counter
//   WDRESET       in  async active-high reset, doubles as the kick acknowledge
//   enable        in  1 = periodic kicking active
//   kick_inhibit  in  (WDKICK_INHIBIT_EN only) hold WAIT at zero, no new kick
//   interval      in  WAIT length in ticks, sampled when WAIT is entered
//   nreset_in     in  observed system nRESET, 0 = abort and hold idle
//   nLDS          out lower data strobe, active low
//   RW            out 1 = read, 0 = write
//   A23I, A22I    out upper address decode lines
//   M68K_ADDR_U   out address bits [21:17]
//   bus_oe        out 1 = kicker owns the bus
//   kick_busy     out 1 while in SETUP/STROBE
//   miss_cnt      out saturating count of consecutive missed kicks
// All outputs are registered.
// ---------------------------------------------------------------------------
module watchdog_kicker
    import wd_pkg::*;
#(
    parameter int INTERVAL_W     = 8,
    parameter int STROBE_TIMEOUT = 4,
    parameter int MISS_W         = 4
) (
    input  logic                  WDCLK,
    input  logic                  WDRESET,
    input  logic                  enable,
`ifdef WDKICK_INHIBIT_EN
    input  logic                  kick_inhibit,
`endif
    input  logic [INTERVAL_W-1:0] interval,
    input  logic                  nreset_in,
    output logic                  nLDS,
    output logic                  RW,
    output logic                  A23I,
    output logic                  A22I,
    output logic [4:0]            M68K_ADDR_U,
    output logic                  bus_oe,
    output logic                  kick_busy,
    output logic [MISS_W-1:0]     miss_cnt
);

    localparam logic [INTERVAL_W-1:0] CNT_ONE     = {{(INTERVAL_W-1){1'b0}}, 1'b1};
    localparam logic [INTERVAL_W-1:0] STROBE_LOAD = INTERVAL_W'(STROBE_TIMEOUT - 1);
    localparam logic [MISS_W-1:0]     MISS_ONE    = {{(MISS_W-1){1'b0}}, 1'b1};

    // Saturating increment of the consecutive-miss counter.
    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + MISS_ONE;
        end
    endfunction

    wd_state_e             state_q, state_d;
    logic [INTERVAL_W-1:0] cnt_q, cnt_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic                  inhibit_s;
    logic                  bus_phase_s;

    logic                  nlds_q, nlds_d;
    logic                  rw_q, rw_d;
    logic                  a23_q, a23_d;
    logic                  a22_q, a22_d;
    logic [4:0]            addr_q, addr_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;

`ifdef WDKICK_INHIBIT_EN
    assign inhibit_s = kick_inhibit;
`else
    assign inhibit_s = 1'b0;
`endif

    // Next-state logic: one down-counter serves both the WAIT interval and
    // the STROBE timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        if (!nreset_in) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = WAIT;
                        cnt_d   = interval;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (!inhibit_s) begin
                        state_d = SETUP;
                    end else begin
                        state_d = WAIT;
                    end
                end
                // A bus cycle always completes once started, even if enable drops.
                SETUP: begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LOAD;
                end
                STROBE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        state_d = FAIL;
                        miss_d  = sat_inc(miss_q);
                    end
                end
                FAIL: begin
                    state_d = WAIT;
                    cnt_d   = interval;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they belong to.
    always_comb begin
        bus_phase_s = (state_d == SETUP) || (state_d == STROBE);
        oe_d        = bus_phase_s;
        busy_d      = bus_phase_s;
        rw_d        = !bus_phase_s;
        nlds_d      = (state_d != STROBE);
        if (bus_phase_s) begin
            addr_d = WD_KICK_ADDR_U;
            a23_d  = WD_KICK_A23;
            a22_d  = WD_KICK_A22;
        end else begin
            addr_d = 5'b00000;
            a23_d  = 1'b0;
            a22_d  = 1'b0;
        end
    end

    // State, counter and output registers; WDRESET is also the kick acknowledge.
    always_ff @(posedge WDCLK or posedge WDRESET) begin
        if (WDRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            miss_q  <= '0;
            nlds_q  <= 1'b1;
            rw_q    <= 1'b1;
            a23_q   <= 1'b0;
            a22_q   <= 1'b0;
            addr_q  <= 5'b00000;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            nlds_q  <= nlds_d;
            rw_q    <= rw_d;
            a23_q   <= a23_d;
            a22_q   <= a22_d;
            addr_q  <= addr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    assign nLDS        = nlds_q;
    assign RW          = rw_q;
    assign A23I        = a23_q;
    assign A22I        = a22_q;
    assign M68K_ADDR_U = addr_q;
    assign bus_oe      = oe_q;
    assign kick_busy   = busy_q;
    assign miss_cnt    = miss_q;

endmodule
